// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store stage (mem_access_unit).
// Optional feature macro used by this slice: MEM_MISALIGN_TRAP_EN.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mau_state_t;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Wide enough for any address width in use; callers cast back to ADDR_W.
  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return {addr[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Shifts the ALU's unshifted byte mask into bus lanes and flags accesses that straddle a word.
// The misaligned flag is consumed only when MEM_MISALIGN_TRAP_EN is defined in the top.
module byte_lane_align
  import mem_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] offset,
  input  logic       is_write,
  output logic [3:0] mem_be,
  output logic       misaligned
);

  logic [7:0] shifted;

  assign shifted = {4'b0000, mask} << offset;

  // Loads always fetch the whole word; lane extraction happens back in the ALU.
  assign mem_be     = is_write ? shifted[3:0] : BE_WORD;
  assign misaligned = |shifted[7:4];

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one request/acknowledge bus transaction per accepted ALU operation.
// Define MEM_MISALIGN_TRAP_EN to turn word-straddling accesses into immediate error responses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_byte,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output mau_state_t        dbg_state
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  mau_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       lane_be;
  logic             misaligned;
  logic             trap;
  logic             timeout;

  byte_lane_align u_align (
    .mask       (req_byte),
    .offset     (req_addr[1:0]),
    .is_write   (req_write),
    .mem_be     (lane_be),
    .misaligned (misaligned)
  );

  assign trap = TRAP_EN & misaligned;

  // Fires on the last allowed REQ cycle; an ack in that same cycle takes priority.
  assign timeout = (TIMEOUT != 0) && (cnt == CNT_LAST) && !mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_we    <= req_write;
            mem_addr  <= ADDR_W'(word_align(64'(req_addr)));
            mem_wdata <= req_wdata;
            mem_be    <= lane_be;
            cnt       <= '0;
            rsp_err   <= trap;
            if (trap) begin
              rsp_rdata <= '0;
              state     <= RESP;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            rsp_rdata <= mem_we ? 32'd0 : mem_rdata;
            state     <= RESP;
          end else if (timeout) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by reset so every output reads 0 while reset is held, even in IDLE.
  assign req_ready = (state == IDLE) & ~reset;
  assign stall     = ~reset & ((state == REQ) | ((state == IDLE) & req_valid));
  assign mem_req   = (state == REQ);
  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model plus per-cycle compare.
// Model follows MEM_MISALIGN_TRAP_EN when the build defines it.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_byte;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  mau_state_t  dbg_state;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_byte  (req_byte),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected run end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        ready;
    logic        stall;
    logic        mreq;
    logic        rvalid;
    logic        rerr;
    logic        chk_mem;
    logic        we;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];

  int n_vec  = 0;
  int n_fail = 0;

  // Model of the response registers as seen by the pipeline.
  logic [31:0] m_rdata = 32'd0;
  logic        m_err   = 1'b0;

  // Observations gathered by the compare process for the directed literal checks.
  int          cyc = 0;
  int          acc_cyc = 0;
  int          obs_req_cyc, obs_stall_cyc, obs_lat;
  logic [31:0] obs_addr, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_we, obs_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset) begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (mem_req) begin
        obs_req_cyc++;
        obs_addr = mem_addr;
        obs_be   = mem_be;
        obs_we   = mem_we;
      end
      if (stall) obs_stall_cyc++;
      if (rsp_valid) begin
        obs_lat   = cyc - acc_cyc;
        obs_rdata = rsp_rdata;
        obs_err   = rsp_err;
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("req_ready", req_ready, e.ready);
      chk("stall", stall, e.stall);
      chk("mem_req", mem_req, e.mreq);
      chk("rsp_valid", rsp_valid, e.rvalid);
      chk("rsp_err", rsp_err, e.rerr);
      chk("rsp_rdata", rsp_rdata, e.rdata);
      if (e.chk_mem) begin
        chk("mem_we", mem_we, e.we);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.wdata);
        chk("mem_be", mem_be, e.be);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t idle_exp(input logic rv);
    exp_t e;
    e       = '0;
    e.ready = 1'b1;
    e.stall = rv;
    e.rerr  = m_err;
    e.rdata = m_rdata;
    return e;
  endfunction

  task automatic obs_clear();
    obs_req_cyc   = 0;
    obs_stall_cyc = 0;
    obs_lat       = -1;
    obs_addr      = 'x;
    obs_rdata     = 'x;
    obs_be        = 'x;
    obs_we        = 1'bx;
    obs_err       = 1'bx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0;
      req_addr  = $urandom;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      step(idle_exp(1'b0));
    end
  endtask

  // ack_at: REQ cycle (1-based) carrying mem_ack; 0 means the bus never answers.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] mask, input int ack_at, input logic [31:0] rdata,
                     input bit hold);
    exp_t e;
    int   shv;
    int   n_req;
    logic trap;
    logic [3:0] be;
    shv = int'(mask) * (1 << addr[1:0]);
    be  = wr ? 4'(shv % 16) : 4'hF;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = (shv > 15);
`else
    trap = 1'b0;
`endif
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_byte  = mask;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    step(idle_exp(1'b1));
    m_err = 1'b0;
    if (trap) begin
      m_err   = 1'b1;
      m_rdata = 32'd0;
    end else begin
      n_req = (ack_at >= 1 && ack_at <= TIMEOUT) ? ack_at : TIMEOUT;
      for (int k = 1; k <= n_req; k++) begin
        req_valid = hold;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        mem_ack   = (k == ack_at);
        mem_rdata = (k == ack_at) ? rdata : $urandom;
        e         = '0;
        e.stall   = 1'b1;
        e.mreq    = 1'b1;
        e.rerr    = m_err;
        e.rdata   = m_rdata;
        e.chk_mem = 1'b1;
        e.we      = wr;
        e.addr    = addr & ~32'd3;
        e.wdata   = wdata;
        e.be      = be;
        step(e);
      end
      if (ack_at >= 1 && ack_at <= TIMEOUT) begin
        m_err   = 1'b0;
        m_rdata = wr ? 32'd0 : rdata;
      end else begin
        m_err   = 1'b1;
        m_rdata = 32'd0;
      end
    end
    req_valid = hold;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    e         = '0;
    e.rvalid  = 1'b1;
    e.rerr    = m_err;
    e.rdata   = m_rdata;
    step(e);
    req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] masks [3];
    masks[0] = BE_BYTE;
    masks[1] = BE_HALF;
    masks[2] = BE_WORD;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_byte  = 4'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_be", mem_be, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // SW 0x100
    obs_clear();
    txn(1'b1, 32'h100, 32'hDEADBEEF, BE_WORD, 1, 32'h0, 1'b0);
    chk("sw_addr", obs_addr, 32'h100);
    chk("sw_be", obs_be, 4'b1111);
    chk("sw_we", obs_we, 1'b1);
    chk("sw_latency", obs_lat, 2);
    chk("sw_rdata", obs_rdata, 32'h0);
    chk("sw_err", obs_err, 1'b0);
    idle(1);

    // SB 0x203
    obs_clear();
    txn(1'b1, 32'h203, 32'h5A5A5A5A, BE_BYTE, 2, 32'h0, 1'b0);
    chk("sb_addr", obs_addr, 32'h200);
    chk("sb_be", obs_be, 4'b1000);

    // LW 0x204, ack in third REQ cycle
    obs_clear();
    txn(1'b0, 32'h204, 32'h0, BE_WORD, 3, 32'h12345678, 1'b0);
    chk("lw_rdata", obs_rdata, 32'h12345678);
    chk("lw_stall_cycles", obs_stall_cyc, 4);
    chk("lw_latency", obs_lat, 4);
    idle(1);

    // Load with no ack -> timeout
    obs_clear();
    txn(1'b0, 32'h300, 32'h0, BE_WORD, 0, 32'h0, 1'b0);
    chk("to_req_cycles", obs_req_cyc, 15);
    chk("to_err", obs_err, 1'b1);
    chk("to_rdata", obs_rdata, 32'h0);
    chk("to_latency", obs_lat, 16);
    chk("to_mem_req_after", mem_req, 1'b0);
    idle(1);

    // SH 0x103: straddles the word
    obs_clear();
    txn(1'b1, 32'h103, 32'hA5A5A5A5, BE_HALF, 1, 32'h0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("sh_mis_req_cycles", obs_req_cyc, 0);
    chk("sh_mis_err", obs_err, 1'b1);
    chk("sh_mis_latency", obs_lat, 1);
`else
    chk("sh_mis_be", obs_be, 4'b1000);
    chk("sh_mis_req_cycles", obs_req_cyc, 1);
    chk("sh_mis_err", obs_err, 1'b0);
`endif
    idle(1);

    // req_valid held through REQ, ack coincides with the timeout cycle
    obs_clear();
    txn(1'b0, 32'h400, 32'h0, BE_WORD, TIMEOUT, 32'hCAFEF00D, 1'b1);
    chk("race_err", obs_err, 1'b0);
    chk("race_rdata", obs_rdata, 32'hCAFEF00D);
    chk("race_req_cycles", obs_req_cyc, 15);
    txn(1'b1, 32'h408, 32'h11223344, BE_WORD, 1, 32'h0, 1'b0);
    idle(1);

    // Reset in the middle of REQ
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h500;
    req_byte  = BE_WORD;
    mem_ack   = 1'b0;
    step(idle_exp(1'b1));
    req_valid = 1'b0;
    chk("pre_rst_mem_req", mem_req, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_req", mem_req, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b0);
    @(posedge clk);
    #3;
    reset   = 1'b0;
    m_err   = 1'b0;
    m_rdata = 32'd0;
    mem_ack = 1'b1;
    mem_rdata = 32'hBADBAD00;
    step(idle_exp(1'b0));
    idle(1);
    obs_clear();
    txn(1'b0, 32'h504, 32'h0, BE_WORD, 2, 32'h0BADF00D, 1'b0);
    chk("post_rst_rdata", obs_rdata, 32'h0BADF00D);
    chk("post_rst_err", obs_err, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic        wr;
      logic [31:0] a;
      int          ack_at;
      wr     = 1'($urandom_range(0, 1));
      a      = $urandom;
      ack_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      txn(wr, a, $urandom, masks[$urandom_range(0, 2)], ack_at, $urandom,
          1'($urandom_range(0, 1)));
      idle(int'($urandom_range(0, 2)));
    end

    idle(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the ALU.
- Takes the ALU's memory request (address, replicated store data, unshifted byte mask, read/write) and runs a request/acknowledge transaction with the data memory.
- Returns the raw memory word for ALU-side load extraction.
- Holds the pipeline stalled while the bus transaction is outstanding.

Parameters:
- ADDR_W, 32, width of request and memory addresses.
- TIMEOUT, 15, cycles in REQ without mem_ack before a bus error; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  ALU presents a memory operation.
- req_ready  out  1  unit accepts the operation this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, already lane-replicated by the ALU.
- req_byte  in  4  unshifted byte mask: 0001 SB, 0011 SH, 1111 SW; ignored for loads.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  raw memory word for a load; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: timeout, or misaligned access when trapping is enabled.
- mem_req  out  1  bus request, held until acknowledged.
- mem_we  out  1  bus write enable.
- mem_addr  out  ADDR_W  word-aligned address, {req_addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  32  registered req_wdata.
- mem_be  out  4  shifted byte enables.
- mem_ack  in  1  bus acknowledge; for loads, mem_rdata is valid in the same cycle.
- mem_rdata  in  32  bus read data.
- stall  out  1  freezes upstream stages.

Behaviour:
- Reset:
  - Asynchronous: state=IDLE and all outputs 0 immediately, including mem_req.
  - A reset mid-transaction abandons it; no response is produced.
- States are IDLE, REQ and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register addr, wdata, write and mask.
  - mem_be = (req_byte << req_addr[1:0]) truncated to 4 bits; loads use mem_be=1111.
  - Go to REQ.
- REQ:
  - mem_req=1; all mem_* outputs stay stable until mem_ack.
  - Timeout counter (width $clog2(TIMEOUT+1)) increments each cycle without ack.
  - On mem_ack: capture mem_rdata (load) or 0 (store) into rsp_rdata, go to RESP.
  - If the counter reaches TIMEOUT with no ack: rsp_err=1, rsp_rdata=0, go to RESP.
  - mem_ack and timeout in the same cycle: ack wins and no error is raised.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=0; a new request is accepted on the following IDLE cycle.
- Latency: accept at cycle 0, mem_req at cycle 1; ack in cycle N gives rsp_valid in cycle N+1. Minimum is 2 cycles from accept to rsp_valid.
- mem_req deasserts in the cycle after ack. mem_ack seen outside REQ is ignored.
- req_valid while state != IDLE is ignored (req_ready=0). Upstream holds its request via stall.
- stall = (state==REQ) | (state==IDLE & req_valid). stall is 0 in RESP so the pipeline advances together with the response.
- rsp_rdata and rsp_err hold their value until the next RESP. rsp_err clears on the next accept.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - An access is misaligned if (req_byte << req_addr[1:0]) loses bits, i.e. SH at offset 3 or SW at a nonzero offset. Loads are checked using their width mask, which the ALU supplies on req_byte for loads too.
  - A misaligned access skips REQ and goes IDLE→RESP with rsp_err=1, rsp_rdata=0 and no mem_req.
- Undefined: the mask is truncated and the access is issued normally; no error is raised.

Decomposition:
- mem_pkg holds:
  - state enum mau_state_t {IDLE, REQ, RESP};
  - constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111;
  - function word_align(addr).
- One sub-module, byte_lane_align: combinational; inputs mask, offset and is_write; outputs mem_be and misaligned.
- FSM and timeout counter stay in mem_access_unit.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, mem_ack 1 cycle after mem_req → mem_addr=0x100, mem_be=1111, mem_we=1; rsp_valid 2 cycles after accept, rsp_rdata=0, rsp_err=0.
- SB addr 0x203, wdata 0x5A5A5A5A → mem_addr=0x200, mem_be=1000; LW addr 0x204 with mem_rdata=0x12345678, ack after 3 waits → rsp_rdata=0x12345678, stall high 4 cycles.
- Load with no ack and TIMEOUT=15 → mem_req high 15 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0, mem_req=0.
- Reset asserted while in REQ → mem_req, stall and rsp_valid drop 0 immediately; a later ack is ignored; the next request is served normally.
- SH addr 0x103: with MEM_MISALIGN_TRAP_EN, no mem_req and rsp_err=1 one cycle after accept; without it, mem_be=1000 is issued.
- req_valid held during REQ plus mem_ack in the same cycle as the timeout → second request accepted only after RESP; first response has rsp_err=0.
